intersection_ctrl: RTL and testbench

//  Two-road intersection sequencer (main road / side road) built on the team's traffic-light FSM style.

---
 rtl/ictrl_pkg.sv | 22 ++
 rtl/intersection_ctrl_phase_timer.sv | 28 ++
 rtl/intersection_ctrl.sv | 133 +++++++++++++
 tb/tb_intersection_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ictrl_pkg.sv
// ictrl_pkg
//   Shared types and constants for the intersection controller.
//   - LT_* : 2-bit lamp encodings used on main_light / side_light.
//   - state_t : sequencer states; the enum values are the codes on the phase port.
package ictrl_pkg;

    localparam logic [1:0] LT_RED  = 2'b00;
    localparam logic [1:0] LT_GRN  = 2'b01;
    localparam logic [1:0] LT_YEL  = 2'b10;
    localparam logic [1:0] LT_DARK = 2'b11;

    typedef enum logic [2:0] {
        ALLRED_M = 3'd0,   // all-red clearance before main green
        MAIN_G   = 3'd1,
        MAIN_Y   = 3'd2,
        ALLRED_S = 3'd3,   // all-red clearance before side green
        SIDE_G   = 3'd4,
        SIDE_Y   = 3'd5,
        FLASH    = 3'd6    // night flash, only reachable with ICTRL_NIGHT_FLASH_EN
    } state_t;

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// phase_timer
//   Per-phase cycle counter. Clears to 0, otherwise counts up by one per
//   cycle and sticks at all-ones instead of wrapping, so an indefinitely
//   long phase never looks like a fresh one.
// Ports
//   clk    in   clock
//   reset  in   asynchronous, active-high; count -> 0
//   clear  in   synchronous clear (takes effect on the next edge)
//   count  out  CW-bit cycle count
module phase_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/intersection_ctrl.sv
// intersection_ctrl
//   Main/side road light sequencer. Main rests on green; a latched side-road
//   request pre-empts it after the minimum main green. Yellow and all-red
//   clearance separate every conflicting phase. All times are in clk cycles.
//   Optional night flash is compiled in with `define ICTRL_NIGHT_FLASH_EN.
// Ports
//   clk         in   clock
//   reset       in   asynchronous, active-high (forces red/red at once)
//   side_req    in   side-road vehicle sensor, level, synchronous to clk
//   night       in   night-flash request (ICTRL_NIGHT_FLASH_EN builds only)
//   main_light  out  00 red, 01 green, 10 yellow, 11 dark (registered)
//   side_light  out  same encoding (registered)
//   phase       out  current state code (registered)
module intersection_ctrl
    import ictrl_pkg::*;
#(
    parameter int T_MAIN_MIN = 10,
    parameter int T_SIDE_MIN = 5,
    parameter int T_SIDE_MAX = 20,
    parameter int T_YEL      = 3,
    parameter int T_ALLRED   = 2,
    parameter int T_FLASH    = 4,
    parameter int CW         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
`ifdef ICTRL_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [1:0] main_light,
    output logic [1:0] side_light,
    output logic [2:0] phase
);

    // A state of length T exits on the cycle where timer == T-1.
    localparam logic [CW-1:0] L_MAIN  = CW'(T_MAIN_MIN - 1);
    localparam logic [CW-1:0] L_SMIN  = CW'(T_SIDE_MIN - 1);
    localparam logic [CW-1:0] L_SMAX  = CW'(T_SIDE_MAX - 1);
    localparam logic [CW-1:0] L_YEL   = CW'(T_YEL - 1);
    localparam logic [CW-1:0] L_ALLRD = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] L_FLASH = CW'(T_FLASH - 1);

    state_t        state, nxt;
    logic [CW-1:0] timer;
    logic          clr, flash_tog;
    logic          req_q, req_nxt;
    logic          dark, dark_nxt;
    logic [1:0]    ml_nxt, sl_nxt;
    logic          night_i;

`ifdef ICTRL_NIGHT_FLASH_EN
    assign night_i = night;
`else
    assign night_i = 1'b0;   // FLASH can never be entered
`endif

    phase_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (clr),
        .count (timer)
    );

    always_comb begin
        nxt       = state;
        flash_tog = 1'b0;
        case (state)
            ALLRED_M: if (timer == L_ALLRD) nxt = night_i ? FLASH : MAIN_G;
            MAIN_G:   if (timer >= L_MAIN && req_q) nxt = MAIN_Y;
            MAIN_Y:   if (timer == L_YEL) nxt = ALLRED_S;
            ALLRED_S: if (timer == L_ALLRD) nxt = night_i ? FLASH : SIDE_G;
            SIDE_G:   if ((timer >= L_SMIN && !side_req) || timer == L_SMAX) nxt = SIDE_Y;
            SIDE_Y:   if (timer == L_YEL) nxt = ALLRED_M;
            FLASH: begin
                if (!night_i)
                    nxt = ALLRED_M;
                else if (timer == L_FLASH)
                    flash_tog = 1'b1;
            end
            default:  nxt = ALLRED_M;
        endcase

        // Timer restarts on every state entry; in FLASH it also restarts on
        // each half-period so it doubles as the blink counter.
        clr = (nxt != state) || flash_tog;

        // Clear on entry to side green beats a same-edge set.
        req_nxt = req_q;
        if (state == ALLRED_S && nxt == SIDE_G)
            req_nxt = 1'b0;
        else if (side_req && state != SIDE_G)
            req_nxt = 1'b1;

        // Blink phase always starts lit (yellow/red) on entry to FLASH.
        dark_nxt = (state == FLASH && nxt == FLASH) ? (dark ^ flash_tog) : 1'b0;

        // Lights are decoded from the next state so they change on the same
        // edge as the state register.
        ml_nxt = LT_RED;
        sl_nxt = LT_RED;
        case (nxt)
            MAIN_G: ml_nxt = LT_GRN;
            MAIN_Y: ml_nxt = LT_YEL;
            SIDE_G: sl_nxt = LT_GRN;
            SIDE_Y: sl_nxt = LT_YEL;
            FLASH: begin
                ml_nxt = dark_nxt ? LT_DARK : LT_YEL;
                sl_nxt = dark_nxt ? LT_DARK : LT_RED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ALLRED_M;
            req_q      <= 1'b0;
            dark       <= 1'b0;
            main_light <= LT_RED;
            side_light <= LT_RED;
            phase      <= 3'd0;
        end else begin
            state      <= nxt;
            req_q      <= req_nxt;
            dark       <= dark_nxt;
            main_light <= ml_nxt;
            side_light <= sl_nxt;
            phase      <= nxt;
        end
    end

endmodule

// File: tb/tb_intersection_ctrl.sv
// tb_intersection_ctrl
//   Directed bench for intersection_ctrl with default timing parameters.
//   Lights/phase are packed as {main(2), side(2), phase(3)} for compact
//   expectations. Night-flash scenario builds only with ICTRL_NIGHT_FLASH_EN.
module tb_intersection_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       side_req;
`ifdef ICTRL_NIGHT_FLASH_EN
    logic       night;
`endif
    logic [1:0] main_light, side_light;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;
    int safety_bad = 0;

    // Expected {main, side, phase} per state
    localparam logic [6:0] S_ARM  = 7'b00_00_000;
    localparam logic [6:0] S_MG   = 7'b01_00_001;
    localparam logic [6:0] S_MY   = 7'b10_00_010;
    localparam logic [6:0] S_ARS  = 7'b00_00_011;
    localparam logic [6:0] S_SG   = 7'b00_01_100;
    localparam logic [6:0] S_SY   = 7'b00_10_101;
`ifdef ICTRL_NIGHT_FLASH_EN
    localparam logic [6:0] S_FLA  = 7'b10_00_110;
    localparam logic [6:0] S_FLB  = 7'b11_11_110;
`endif

    always #5 clk = ~clk;

    intersection_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .side_req   (side_req),
`ifdef ICTRL_NIGHT_FLASH_EN
        .night      (night),
`endif
        .main_light (main_light),
        .side_light (side_light),
        .phase      (phase)
    );

    // Safety: never two non-red heads, except the flash pair (10|11 vs 11).
    always @(negedge clk) begin
        if (!reset) begin
            assert (main_light == 2'b00 || side_light == 2'b00 ||
                    (phase == 3'd6 && side_light == 2'b11 && main_light[1]))
            else begin
                safety_bad++;
                $display("safety violation at %0t: main %b side %b phase %0d",
                         $time, main_light, side_light, phase);
            end
        end
    end

    function automatic logic [6:0] cur();
        return {main_light, side_light, phase};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count cycles the current light/phase pattern holds (bounded by limit).
    task automatic measure(input int limit, output int n);
        logic [6:0] st;
        st = cur();
        n  = 0;
        while (cur() === st && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        side_req = 1'b0;
`ifdef ICTRL_NIGHT_FLASH_EN
        night    = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] st;
        int n;
        do_reset();
        st = cur(); measure(10, n); tests++;
        if (st !== S_ARM || n != 2) begin fails++;
            $display("FAIL reset_allred: got %b n=%0d, want %b n=2", st, n, S_ARM); end
        st = cur(); measure(100, n); tests++;
        if (st !== S_MG || n != 100) begin fails++;
            $display("FAIL main_rest: got %b n=%0d, want %b n=100", st, n, S_MG); end
    endtask

    task automatic test_preempt();
        logic [6:0] st;
        int n;
        do_reset();
        measure(10, n);            // through initial all-red
        tick(); tick(); tick();    // main green cycle 3
        side_req = 1'b1;
        tick();
        side_req = 1'b0;           // now at main green cycle 4
        st = cur(); measure(50, n); tests++;
        if (st !== S_MG || n != 6) begin fails++;
            $display("FAIL pre_main_g: got %b n=%0d(+4), want %b n=6(+4)", st, n, S_MG); end
        st = cur(); measure(50, n); tests++;
        if (st !== S_MY || n != 3) begin fails++;
            $display("FAIL pre_main_y: got %b n=%0d, want %b n=3", st, n, S_MY); end
        st = cur(); measure(50, n); tests++;
        if (st !== S_ARS || n != 2) begin fails++;
            $display("FAIL pre_allred_s: got %b n=%0d, want %b n=2", st, n, S_ARS); end
        st = cur(); measure(50, n); tests++;
        if (st !== S_SG || n != 5) begin fails++;
            $display("FAIL pre_side_g_min: got %b n=%0d, want %b n=5", st, n, S_SG); end
        st = cur(); measure(50, n); tests++;
        if (st !== S_SY || n != 3) begin fails++;
            $display("FAIL pre_side_y: got %b n=%0d, want %b n=3", st, n, S_SY); end
        st = cur(); measure(50, n); tests++;
        if (st !== S_ARM || n != 2) begin fails++;
            $display("FAIL pre_allred_m: got %b n=%0d, want %b n=2", st, n, S_ARM); end
        tests++;
        if (cur() !== S_MG) begin fails++;
            $display("FAIL pre_back_main: got %b, want %b", cur(), S_MG); end
    endtask

    // Starts at main green cycle 0.
    task automatic test_side_max();
        logic [6:0] st;
        int n;
        side_req = 1'b1;
        st = cur(); measure(50, n); tests++;
        if (st !== S_MG || n != 10) begin fails++;
            $display("FAIL max_main_g: got %b n=%0d, want %b n=10", st, n, S_MG); end
        measure(50, n);            // main yellow
        measure(50, n);            // all-red into side
        st = cur(); measure(50, n); tests++;
        if (st !== S_SG || n != 20) begin fails++;
            $display("FAIL max_side_g: got %b n=%0d, want %b n=20", st, n, S_SG); end
        st = cur(); measure(50, n); tests++;
        if (st !== S_SY || n != 3) begin fails++;
            $display("FAIL max_side_y: got %b n=%0d, want %b n=3", st, n, S_SY); end
        measure(50, n);            // all-red into main
        side_req = 1'b0;
        st = cur(); measure(50, n); tests++;
        if (st !== S_MG || n != 10) begin fails++;
            $display("FAIL max_relatch_main_g: got %b n=%0d, want %b n=10", st, n, S_MG); end
    endtask

    // Starts at main yellow cycle 0 with a request still latched.
    task automatic test_back_to_back();
        logic [6:0] st;
        int n, k;
        measure(50, n);            // main yellow
        tick();                    // last all-red cycle
        side_req = 1'b1;           // seen on the edge entering side green
        tick();
        side_req = 1'b0;
        st = cur(); measure(50, n); tests++;
        if (st !== S_SG || n != 5) begin fails++;
            $display("FAIL clr_side_g: got %b n=%0d, want %b n=5", st, n, S_SG); end
        measure(50, n);            // side yellow
        measure(50, n);            // all-red into main
        st = cur(); measure(30, n); tests++;
        if (st !== S_MG || n != 30) begin fails++;
            $display("FAIL clr_wins_main_rest: got %b n=%0d, want %b n=30", st, n, S_MG); end
        // Drive into side yellow, then reset mid-phase.
        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        k = 0;
        while (phase !== 3'd5 && k < 40) begin tick(); k++; end
        tests++;
        if (phase !== 3'd5) begin fails++;
            $display("FAIL reach_side_y: got phase %0d after %0d cycles, want 5", phase, k); end
        tick();
        reset = 1'b1;
        #1;
        tests++;
        if (cur() !== S_ARM) begin fails++;
            $display("FAIL async_reset: got %b, want %b", cur(), S_ARM); end
        tick();
        reset = 1'b0;
        st = cur(); measure(10, n); tests++;
        if (st !== S_ARM || n != 2 || cur() !== S_MG) begin fails++;
            $display("FAIL restart: got %b n=%0d then %b, want %b n=2 then %b",
                     st, n, cur(), S_ARM, S_MG); end
    endtask

`ifdef ICTRL_NIGHT_FLASH_EN
    task automatic test_night();
        logic [6:0] st;
        int n;
        do_reset();
        measure(10, n);
        night = 1'b1;
        st = cur(); measure(20, n); tests++;
        if (st !== S_MG || n != 20) begin fails++;
            $display("FAIL night_main_hold: got %b n=%0d, want %b n=20", st, n, S_MG); end
        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        measure(20, n);            // remaining main green
        measure(20, n);            // main yellow
        measure(20, n);            // all-red into side
        st = cur(); measure(20, n); tests++;
        if (st !== S_FLA || n != 4) begin fails++;
            $display("FAIL flash_a: got %b n=%0d, want %b n=4", st, n, S_FLA); end
        st = cur(); measure(20, n); tests++;
        if (st !== S_FLB || n != 4) begin fails++;
            $display("FAIL flash_b: got %b n=%0d, want %b n=4", st, n, S_FLB); end
        tests++;
        if (cur() !== S_FLA) begin fails++;
            $display("FAIL flash_a2: got %b, want %b", cur(), S_FLA); end
        night = 1'b0;
        tick();
        st = cur(); measure(10, n); tests++;
        if (st !== S_ARM || n != 2 || cur() !== S_MG) begin fails++;
            $display("FAIL flash_exit: got %b n=%0d then %b, want %b n=2 then %b",
                     st, n, cur(), S_ARM, S_MG); end
    endtask
`endif

    initial begin
        reset    = 1'b1;
        side_req = 1'b0;
`ifdef ICTRL_NIGHT_FLASH_EN
        night    = 1'b0;
`endif
        #1;
        tests++;
        if (cur() !== S_ARM) begin fails++;
            $display("FAIL reset_state: got %b, want %b", cur(), S_ARM); end
        test_reset();
        test_preempt();
        test_side_max();
        test_back_to_back();
`ifdef ICTRL_NIGHT_FLASH_EN
        test_night();
`endif
        tests++;
        if (safety_bad != 0) begin fails++;
            $display("FAIL safety_invariant: got %0d violations, want 0", safety_bad); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
